fp_pack_stage: RTL and testbench
================================

FP_PACK_STAGE -- requirements
Module: fp_pack_stage

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa width (hidden bit excluded).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream adder result present.
REQ-006 SHALL have port in_ready  output  1  stage accepts input this cycle.
REQ-007 SHALL have port in_sign  input  1  result sign.
REQ-008 SHALL have port in_exponent  input  EXP_W  biased exponent from the normaliser (final_exponent).
REQ-009 SHALL have port in_mantissa  input  MAN_W  normalised mantissa (normal_mantissa_sum).
REQ-010 SHALL have port in_grs  input  3  guard, round, sticky bits, MSB first.
REQ-011 SHALL have port out_valid  output  1  packed word present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_word  output  1+EXP_W+MAN_W  packed IEEE-754 word {sign, exponent, mantissa}.
REQ-014 SHALL have port out_overflow  output  1  result saturated to infinity.
REQ-015 SHALL have port out_zero  output  1  result is signed zero.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 = round, S2 = pack/exception; out_* driven directly from S2 registers.
REQ-017 SHALL use advance = out_ready | ~s2_valid; in_ready = advance; both stages load only when advance = 1.
REQ-018 SHALL accept a transfer when in_valid & in_ready; out transfer occurs when out_valid & out_ready.
REQ-019 SHALL give 2-cycle latency: an input accepted at edge N appears on out_* after edge N+1 (valid through edge N+2) when no stall.
REQ-020 SHALL, when advance = 0, hold S1, S2 and all out_* unchanged; no item is lost or duplicated, order preserved.
REQ-021 SHALL, when advance = 1 and in_valid = 0, load a bubble into S1 (s1_valid = 0).
REQ-022 SHALL round in S1 (see REQ-030); a carry out of the mantissa SHALL clear the mantissa and increment the exponent.
REQ-023 SHALL, in S2, force exponent all-ones and mantissa 0, with out_overflow = 1, when the S1 exponent equals all-ones (input or after increment).
REQ-024 SHALL, in S2, force exponent 0 and mantissa 0, with out_zero = 1, when in_exponent = 0 (denormals flushed); sign passes through.
REQ-025 SHALL hold out_overflow and out_zero at 0 whenever out_valid = 0.
REQ-026 SHALL, on simultaneous input accept and output drain, move every stage forward in the same cycle.

Reset
REQ-027 SHALL, on rst = 1 at a clock edge, clear s1_valid, s2_valid, out_word, out_overflow and out_zero to 0, dropping in-flight items.
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset release.
REQ-029 SHALL give rst priority over any simultaneous transfer.

Configuration
REQ-030 SHALL, with FP_PACK_RNE_EN defined, round to nearest even: increment when G & (R | S | mantissa LSB).
REQ-031 SHALL, without FP_PACK_RNE_EN, truncate: in_grs is ignored and the mantissa is never incremented.

Structure
REQ-032 SHALL place EXP_W/MAN_W defaults, EXP_INF (all-ones) and word-width constants in shared package fp_pkg.
REQ-033 SHALL implement the S1 rounding logic as combinational sub-module fp_round (mantissa, exponent, grs in; mantissa, exponent out).

Verification
REQ-034 SHALL cover: sign 0, exp 0x7F, man 0x400000, grs 000 -> out_word 0x3FC00000 two cycles later, flags 0.
REQ-035 SHALL cover: exp 0x7F, man 0x7FFFFF, grs 100 -> 0x40000000 with RNE_EN, 0x3FFFFFFF without.
REQ-036 SHALL cover: exp 0xFE, man 0x7FFFFF, grs 110 with RNE_EN -> 0x7F800000, out_overflow = 1.
REQ-037 SHALL cover: sign 1, exp 0x00, man 0x123456 -> 0x80000000, out_zero = 1.
REQ-038 SHALL cover: 4 back-to-back inputs with out_ready = 0 for 3 cycles -> in_ready low once S2 holds data and is stalled; all 4 outputs emerge in order after release.
REQ-039 SHALL cover: rst asserted with 2 items in flight -> next cycle out_valid = 0, out_word = 0, in_ready = 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants for the FP pack stage.
// Default widths (IEEE-754 single), all-ones exponent, packed word width.
package fp_pkg;

  localparam int EXP_W_D = 8;
  localparam int MAN_W_D = 23;
  localparam int WORD_W_D = 1 + EXP_W_D + MAN_W_D;

  localparam logic [EXP_W_D-1:0] EXP_INF = {EXP_W_D{1'b1}};

endpackage

// File: rtl/fp_round.sv
// Combinational rounding of a normalised mantissa.
// In: mant_i, exp_i, grs_i (G,R,S).  Out: mant_o, exp_o.
// FP_PACK_RNE_EN defined: round to nearest even; otherwise truncate.
module fp_round
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_D,
  parameter int MAN_W = MAN_W_D
) (
  input  logic [MAN_W-1:0] mant_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [2:0]       grs_i,
  output logic [MAN_W-1:0] mant_o,
  output logic [EXP_W-1:0] exp_o
);

`ifdef FP_PACK_RNE_EN
  logic           inc;
  logic [MAN_W:0] sum;

  // Ties (G set, R and S clear) go to the even mantissa.
  assign inc = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
  assign sum = {1'b0, mant_i} + {{MAN_W{1'b0}}, inc};

  // A carry out leaves the low MAN_W bits at zero.
  assign mant_o = sum[MAN_W-1:0];
  assign exp_o  = exp_i + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
`else
  logic unused_grs;

  assign unused_grs = ^grs_i;
  assign mant_o     = mant_i;
  assign exp_o      = exp_i;
`endif

endmodule

// File: rtl/fp_pack_stage.sv
// Two-stage round/pack pipeline producing an IEEE-754 word.
// S1 registers the rounded value; S2 packs with inf/zero exceptions.
// Ports: clk, rst (sync, high); in_valid/in_ready, in_sign,
//   in_exponent, in_mantissa, in_grs; out_valid/out_ready,
//   out_word, out_overflow, out_zero.
// Build option: FP_PACK_RNE_EN enables round-to-nearest-even.
module fp_pack_stage
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_D,
  parameter int MAN_W = MAN_W_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exponent,
  input  logic [MAN_W-1:0]       in_mantissa,
  input  logic [2:0]             in_grs,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_word,
  output logic                   out_overflow,
  output logic                   out_zero
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] ONES = {EXP_W{1'b1}};

  logic             adv;
  logic [MAN_W-1:0] rnd_man;
  logic [EXP_W-1:0] rnd_exp;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W-1:0] s1_man_q, s1_man_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             s1_zero_q, s1_zero_d;

  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_word_q, s2_word_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_zero_q, s2_zero_d;

  // S2 empty or draining: the whole pipe may shift.
  assign adv      = out_ready | ~s2_valid_q;
  assign in_ready = adv;

  fp_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round (
    .mant_i(in_mantissa),
    .exp_i (in_exponent),
    .grs_i (in_grs),
    .mant_o(rnd_man),
    .exp_o (rnd_exp)
  );

  always_comb begin
    s1_valid_d = in_valid;
    s1_sign_d  = in_sign;
    s1_exp_d   = rnd_exp;
    s1_man_d   = rnd_man;
    // Check the raw exponent too: a carry from all-ones wraps.
    s1_ovf_d   = (in_exponent == ONES) | (rnd_exp == ONES);
    s1_zero_d  = (in_exponent == '0);
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_word_d  = {s1_sign_q, s1_exp_q, s1_man_q};
    s2_ovf_d   = 1'b0;
    s2_zero_d  = 1'b0;
    unique case (1'b1)
      s1_zero_q: begin
        s2_word_d = {s1_sign_q, {(W-1){1'b0}}};
        s2_zero_d = s1_valid_q;
      end
      s1_ovf_q: begin
        s2_word_d = {s1_sign_q, ONES, {MAN_W{1'b0}}};
        s2_ovf_d  = s1_valid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_ovf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
      s2_ovf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_word     = s2_word_q;
  assign out_overflow = s2_ovf_q;
  assign out_zero     = s2_zero_q;

endmodule

// File: tb/tb_fp_pack_stage.sv
// Directed bench for fp_pack_stage (single precision).
// Expectations follow the FP_PACK_RNE_EN build setting.
module tb_fp_pack_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [22:0] in_mantissa;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_overflow;
  logic        out_zero;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_pack_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .in_grs      (in_grs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_overflow(out_overflow),
    .out_zero    (out_zero)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic [2:0]  grs;
    logic [31:0] w_rne;
    logic [31:0] w_trn;
    logic        ovf_rne;
    logic        ovf_trn;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] e,
                       input logic [22:0] m, input logic [2:0] g);
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    in_grs      = g;
  endtask

  logic [31:0] exp_q[4];
  logic [31:0] w;
  logic        o;
  logic        rne;
  int          n_in;
  int          n_out;
  int          cyc;
  bit          acc;
  bit          drn;
  bit          stall_ok;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
`ifdef FP_PACK_RNE_EN
    rne = 1'b1;
`else
    rne = 1'b0;
`endif
    vecs[0] = '{1'b0, 8'h7F, 23'h400000, 3'b000,
                32'h3FC00000, 32'h3FC00000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b100,
                32'h40000000, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b110,
                32'h7F800000, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 23'h123456, 3'b000,
                32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 23'h000001, 3'b000,
                32'hFF800000, 32'hFF800000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h7F, 23'h000000, 3'b100,
                32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h7F, 23'h000002, 3'b101,
                32'h3F800003, 32'h3F800002, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 23'h000001, 3'b100,
                32'h40000002, 32'h40000001, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 23'h0, 3'b000);
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_word", out_word, 32'h0);
    chk("rst_flags", {30'b0, out_overflow, out_zero}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      w = rne ? vecs[i].w_rne : vecs[i].w_trn;
      o = rne ? vecs[i].ovf_rne : vecs[i].ovf_trn;
      drive(vecs[i].sign, vecs[i].exp, vecs[i].man, vecs[i].grs);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), {31'b0, out_valid}, 32'd0);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_word", i), out_word, w);
      chk($sformatf("v%0d_ovf", i), {31'b0, out_overflow}, {31'b0, o});
      chk($sformatf("v%0d_zero", i), {31'b0, out_zero},
          {31'b0, vecs[i].zero});
      step();
      chk($sformatf("v%0d_bubble", i),
          {29'b0, out_valid, out_overflow, out_zero}, 32'd0);
    end

    // Back-to-back stream against a three-cycle output stall.
    for (int i = 0; i < 4; i++)
      exp_q[i] = {1'b0, 8'h10 + 8'(i), 23'(i * 3 + 1)};
    n_in     = 0;
    n_out    = 0;
    cyc      = 0;
    stall_ok = 1'b1;
    while (n_out < 4 && cyc < 40) begin
      in_valid = (n_in < 4);
      drive(1'b0, 8'h10 + 8'(n_in), 23'(n_in * 3 + 1), 3'b000);
      out_ready = (cyc >= 5);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        if (in_ready !== 1'b0 || out_word !== exp_q[0])
          stall_ok = 1'b0;
      end
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        chk($sformatf("stream_%0d", n_out), out_word, exp_q[n_out]);
        n_out++;
      end
      @(posedge clk);
      if (acc) n_in++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stall_hold", {31'b0, stall_ok}, 32'd1);
    chk("stream_count", n_out, 32'd4);
    step();
    chk("stream_drained", {31'b0, out_valid}, 32'd0);

    // Reset with two items in flight, and a new input offered.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(1'b0, 8'h7F, 23'h1, 3'b000);
    step();
    drive(1'b0, 8'h7E, 23'h2, 3'b000);
    step();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 8'h7D, 23'h3, 3'b000);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_word", out_word, 32'h0);
    chk("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("rst2_s1_flushed", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
